// File: rtl/usb_tb_pkg.sv
// Shared types and constants for the host-side full-speed USB transmitter.
package usb_tb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    // Line symbols as {d_p, d_n}
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LIMIT  = 6;

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI encoder plus consecutive-ones tracker; o_sym is the symbol the strobed bit would produce.
module usb_nrzi_stuffer
    import usb_tb_pkg::*;
(
    input  logic       clk48_host,
    input  logic       reset,
    input  logic       i_init,
    input  logic       i_strobe,
    input  logic       i_bit,
    output logic [1:0] o_sym,
    output logic       o_stuff_insert
);

    logic       r_lvl;   // 1 = J
    logic [2:0] r_ones;
    logic       w_base;
    logic       w_lvl;

    // A packet start always encodes relative to J, whatever the previous packet left behind.
    assign w_base         = i_init ? 1'b1 : r_lvl;
    assign w_lvl          = i_bit ? w_base : ~w_base;
    assign o_sym          = w_lvl ? SYM_J : SYM_K;
    assign o_stuff_insert = (r_ones == 3'(STUFF_LIMIT));

    always_ff @(posedge clk48_host) begin
        if (reset) begin
            r_lvl  <= 1'b1;
            r_ones <= 3'd0;
        end else if (i_strobe) begin
            r_lvl <= w_lvl;
            if (!i_bit)
                r_ones <= 3'd0;
            else if (i_init)
                r_ones <= 3'd1;
            else
                r_ones <= r_ones + 3'd1;
        end
    end

endmodule

// File: rtl/usb_host_fs_tx.sv
// Full-speed USB host transmitter: byte stream in, SYNC/data/stuffing/NRZI/EOP out on D+/D-.
module usb_host_fs_tx
    import usb_tb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk48_host,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_d_p,
    output logic       usb_d_n,
    output logic       usb_oe,
    output logic       busy,
    output logic       underrun
);

    localparam int             PW      = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0]  PH_LAST = PW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_last;
    logic [1:0]    r_line;
    logic          r_oe;
    logic          r_busy;
    logic          r_underrun;

    logic       w_tick;
    logic       w_init;
    logic       w_strobe;
    logic       w_bit;
    logic       w_stuff;
    logic       w_byte_end;
    logic [1:0] w_sym;
    logic [2:0] w_bitnxt;

    assign w_tick     = (r_state != IDLE) && (r_phase == PH_LAST);
    assign w_bitnxt   = r_bitcnt + 3'd1;
    // Byte boundary is the end of bit 7, or of the stuff bit that follows it.
    assign w_byte_end = w_tick && (r_bitcnt == 3'd7) &&
                        (((r_state == DATA) && !w_stuff) || (r_state == STUFF));
    assign tx_ready   = (r_state == IDLE) || (w_byte_end && !r_last);

    assign usb_d_p  = r_line[1];
    assign usb_d_n  = r_line[0];
    assign usb_oe   = r_oe;
    assign busy     = r_busy;
    assign underrun = r_underrun;

    // Choose the bit that starts on the coming edge, if any.
    always_comb begin
        w_init   = 1'b0;
        w_strobe = 1'b0;
        w_bit    = 1'b0;
        if (r_state == IDLE) begin
            w_init   = tx_valid;
            w_strobe = tx_valid;
            w_bit    = SYNC_PATTERN[0];
        end else if (w_tick) begin
            case (r_state)
                SYNC: begin
                    w_strobe = 1'b1;
                    w_bit    = (r_bitcnt == 3'd7) ? r_shreg[0] : SYNC_PATTERN[w_bitnxt];
                end
                DATA, STUFF: begin
                    if ((r_state == DATA) && w_stuff) begin
                        w_strobe = 1'b1;
                        w_bit    = 1'b0;
                    end else if (r_bitcnt != 3'd7) begin
                        w_strobe = 1'b1;
                        w_bit    = r_shreg[1];
                    end else if (!r_last && tx_valid) begin
                        w_strobe = 1'b1;
                        w_bit    = tx_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    usb_nrzi_stuffer u_nrzi (
        .clk48_host     (clk48_host),
        .reset          (reset),
        .i_init         (w_init),
        .i_strobe       (w_strobe),
        .i_bit          (w_bit),
        .o_sym          (w_sym),
        .o_stuff_insert (w_stuff)
    );

    always_ff @(posedge clk48_host) begin
        if (reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_bitcnt   <= 3'd0;
            r_shreg    <= 8'd0;
            r_last     <= 1'b0;
            r_line     <= SYM_J;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (r_state == IDLE) begin
                if (tx_valid) begin
                    r_shreg  <= tx_data;
                    r_last   <= tx_last;
                    r_state  <= SYNC;
                    r_bitcnt <= 3'd0;
                    r_phase  <= '0;
                    r_oe     <= 1'b1;
                    r_busy   <= 1'b1;
                    r_line   <= w_sym;
                end
            end else begin
                r_phase <= w_tick ? '0 : r_phase + 1'b1;
                if (w_tick) begin
                    case (r_state)
                        SYNC: begin
                            r_line <= w_sym;
                            if (r_bitcnt == 3'd7) begin
                                r_state  <= DATA;
                                r_bitcnt <= 3'd0;
                            end else begin
                                r_bitcnt <= w_bitnxt;
                            end
                        end
                        DATA, STUFF: begin
                            if ((r_state == DATA) && w_stuff) begin
                                r_state <= STUFF;
                                r_line  <= w_sym;
                            end else if (r_bitcnt != 3'd7) begin
                                r_state  <= DATA;
                                r_bitcnt <= w_bitnxt;
                                r_shreg  <= r_shreg >> 1;
                                r_line   <= w_sym;
                            end else if (!r_last && tx_valid) begin
                                r_state  <= DATA;
                                r_bitcnt <= 3'd0;
                                r_shreg  <= tx_data;
                                r_last   <= tx_last;
                                r_line   <= w_sym;
                            end else begin
                                r_underrun <= !r_last;
                                r_state    <= EOP_SE0;
                                r_bitcnt   <= 3'd0;
                                r_line     <= SYM_SE0;
                            end
                        end
                        EOP_SE0: begin
                            if (r_bitcnt == 3'd0) begin
                                r_bitcnt <= 3'd1;
                            end else begin
                                r_state <= EOP_J;
                                r_line  <= SYM_J;
                            end
                        end
                        EOP_J: begin
                            r_state <= IDLE;
                            r_oe    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_phase <= '0;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_host_fs_tx.sv
// Randomized packet bench for usb_host_fs_tx against a bit-list NRZI/stuffing reference model.
module tb_usb_host_fs_tx;
    import usb_tb_pkg::*;

    localparam int C    = 4;
    localparam int MAXC = 3000;

    logic       clk48_host = 1'b0;
    logic       reset      = 1'b1;
    logic [7:0] tx_data    = 8'd0;
    logic       tx_valid   = 1'b0;
    logic       tx_last    = 1'b0;
    logic       tx_ready;
    logic       usb_d_p;
    logic       usb_d_n;
    logic       usb_oe;
    logic       busy;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt[$];
    int         nsend;
    logic [5:0] rec[$];  // {oe, busy, ready, underrun, d_p, d_n}
    logic [5:0] exq[$];

    usb_host_fs_tx #(.CLKS_PER_BIT(C)) dut (
        .clk48_host (clk48_host),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .usb_d_p    (usb_d_p),
        .usb_d_n    (usb_d_n),
        .usb_oe     (usb_oe),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk48_host = ~clk48_host;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle trace from the line-coding rules, one sample per clock.
    task automatic model();
        logic [7:0] sp;
        int         rawb[$];
        int         bendf[$];
        logic [1:0] symq[$];
        int         bend[$];
        bit         lvl;
        int         ones;
        int         nb;
        int         urk;
        bit         r;
        bit         u;
        sp   = SYNC_PATTERN;
        lvl  = 1'b1;
        ones = 0;
        nb   = pkt.size();
        exq.delete();
        for (int i = 0; i < 8; i++) begin
            rawb.push_back(int'(sp[i]));
            bendf.push_back(-1);
        end
        for (int j = 0; j < nsend; j++)
            for (int i = 0; i < 8; i++) begin
                rawb.push_back(int'(pkt[j][i]));
                bendf.push_back(i == 7 ? j : -1);
            end
        foreach (rawb[i]) begin
            if (rawb[i] == 0) lvl = !lvl;
            symq.push_back(lvl ? SYM_J : SYM_K);
            ones = (rawb[i] != 0) ? ones + 1 : 0;
            if (ones == STUFF_LIMIT) begin
                lvl = !lvl;
                symq.push_back(lvl ? SYM_J : SYM_K);
                ones = 0;
            end
            if (bendf[i] >= 0) bend.push_back(symq.size() - 1);
        end
        urk = (nsend < nb) ? bend[nsend-1] + 1 : -1;
        symq.push_back(SYM_SE0);
        symq.push_back(SYM_SE0);
        symq.push_back(SYM_J);
        exq.push_back({1'b0, 1'b0, 1'b1, 1'b0, SYM_J});
        foreach (symq[k])
            for (int p = 0; p < C; p++) begin
                r = 1'b0;
                for (int j = 0; j < nsend && j < nb - 1; j++)
                    if (bend[j] == k && p == C - 1) r = 1'b1;
                u = (p == 0) && (k == urk);
                exq.push_back({1'b1, 1'b1, r, u, symq[k]});
            end
        exq.push_back({1'b0, 1'b0, 1'b1, 1'b0, SYM_J});
    endtask

    // Drives pkt (first nsend bytes offered) and records until busy falls; returns at that negedge.
    task automatic run_pkt(input bit b2b, input string tag);
        int  nb;
        int  idx;
        bit  seen;
        bit  done;
        bit  acc;
        int  n;
        nb   = pkt.size();
        idx  = 0;
        seen = 0;
        done = 0;
        rec.delete();
        tx_data  = pkt[0];
        tx_last  = (nb == 1);
        tx_valid = 1'b1;
        for (int c = 0; c < MAXC; c++) begin
            if (c == 0 && b2b) #1;
            else @(negedge clk48_host);
            rec.push_back({usb_oe, busy, tx_ready, underrun, usb_d_p, usb_d_n});
            acc = tx_valid && tx_ready;
            if (seen && !busy) begin
                done = 1;
                break;
            end
            if (busy) seen = 1;
            @(posedge clk48_host);
            #1;
            if (acc) begin
                idx++;
                if (idx < nsend) begin
                    tx_data = pkt[idx];
                    tx_last = (idx == nb - 1);
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
        end
        tx_valid = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        model();
        chk({tag, "_len"}, rec.size(), exq.size());
        n = (rec.size() < exq.size()) ? rec.size() : exq.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(rec[i]), 32'(exq[i]));
    endtask

    task automatic realign(input int gap);
        repeat (gap + 1) @(posedge clk48_host);
        #1;
    endtask

    initial begin
        int  nb;
        bit  b2b;
        repeat (3) @(posedge clk48_host);
        #1;
        chk("rst_oe", usb_oe, 1'b0);
        chk("rst_dp", usb_d_p, 1'b1);
        chk("rst_dn", usb_d_n, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ur", underrun, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        reset = 1'b0;
        realign(1);

        pkt = '{8'hA5};                 nsend = 1; run_pkt(0, "a5");   realign(2);
        pkt = '{8'hFF};                 nsend = 1; run_pkt(0, "ff");   realign(2);
        pkt = '{8'h01, 8'h02, 8'h03};   nsend = 3; run_pkt(0, "three"); realign(2);
        pkt = '{8'h3C, 8'hC3};          nsend = 1; run_pkt(0, "under");
        pkt = '{8'hFF, 8'h7E};          nsend = 2; run_pkt(1, "b2b");  realign(1);

        // Reset in the middle of the first data byte.
        tx_data  = 8'h5A;
        tx_last  = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk48_host);
        #1;
        repeat (44) @(posedge clk48_host);
        #1;
        chk("mid_busy", busy, 1'b1);
        reset    = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk48_host);
        #1;
        chk("mr_oe", usb_oe, 1'b0);
        chk("mr_line", {usb_d_p, usb_d_n}, SYM_J);
        chk("mr_busy", busy, 1'b0);
        chk("mr_ready", tx_ready, 1'b1);
        reset = 1'b0;
        realign(1);
        pkt = '{8'h00, 8'hFE}; nsend = 2; run_pkt(0, "post_rst"); realign(0);

        for (int t = 0; t < 16; t++) begin
            nb = $urandom_range(1, 4);
            pkt.delete();
            for (int j = 0; j < nb; j++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            nsend = (nb > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, nb - 1) : nb;
            b2b = (t > 0) && ($urandom_range(0, 2) == 0);
            if (!b2b && t > 0) realign($urandom_range(0, 3));
            run_pkt(b2b, $sformatf("rnd%0d", t));
        end
        realign(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
